reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
// - Parametrised successor to the two-flop POR synchroniser. Asserts N_OUT active-low resets
//   asynchronously and releases them synchronously to Clk, in a fixed order.
// - Release sequence: SYNC_STAGES-deep synchroniser, then a stretch hold, then one output per
//   STEP_CYCLES (index 0 first).
// - Sits at the top of each clock domain. Drives per-subsystem reset trees: bus, core, periph, ...
// PARAMETERS
// - SYNC_STAGES     2   synchroniser flops on deassertion path; >=2, else $error at elaboration
// - N_OUT           4   number of sequenced reset outputs; >=1
// - STRETCH_CYCLES  16  Clk cycles held after synchroniser output rises; >=1
// - STEP_CYCLES     8   Clk cycles between consecutive output releases; >=1
// PORTS
// - Clk         in   1      clock, rising edge
// - Asyncrst_n  in   1      reset, asynchronous, active-low
// - Sw_rst      in   1      synchronous software reset request, active-high (only with RSTSEQ_SWRST_EN)
// - Rst_n       out  N_OUT  sequenced resets, active-low; bit i released after bit i-1
// - Rst_done    out  1      high once every Rst_n bit is released
// BEHAVIOUR
// - Reset is decided: Asyncrst_n is asynchronous and active-low; the clock is Clk.
// - Asyncrst_n low: synchroniser chain, FSM, counter and all outputs clear immediately,
//   with no clock needed.
//   - Rst_n = 0 (all bits), Rst_done = 0, state = SYNC.
// - Synchroniser: chain D tied high, shifts 1 per edge. Output sync_ok rises on edge SYNC_STAGES
//   after the Asyncrst_n rise. The edge count is from the first rising edge after the rise.
// - All outputs are registered. No combinational path from any input to an output.
// - FSM states and transitions:
//   - SYNC: wait for sync_ok. Then HOLD, counter = 0.
//   - HOLD: count STRETCH_CYCLES edges. At the last one, set Rst_n[0] = 1 and go to RELEASE,
//     counter = 0, idx = 1.
//     - If N_OUT = 1, go straight to DONE and set Rst_done = 1 on that same edge.
//   - RELEASE: count STEP_CYCLES edges. At the last one, set Rst_n[idx] = 1 and increment idx.
//     - When idx reaches N_OUT-1, go to DONE and set Rst_done = 1 on that same edge.
//   - DONE: hold; all Rst_n = 1, Rst_done = 1.
// - Timing with defaults, counted in edges after the Asyncrst_n rise:
//   - Rst_n[0] at edge 18; Rst_n[1] at 26; Rst_n[2] at 34; Rst_n[3] and Rst_done at 42.
//   - General rule: Rst_n[i] at SYNC_STAGES + STRETCH_CYCLES + i*STEP_CYCLES.
// - Rst_n bits are monotonic. Once released, a bit stays high until a reset event.
//   Bits never release out of order.
// - Counter width is $clog2(max(STRETCH_CYCLES, STEP_CYCLES)+1). Counter clears on every
//   state change and never wraps.
// - Asyncrst_n low in any state: immediate full reset as above. The sequence restarts from SYNC
//   on release.
// - Asyncrst_n glitch shorter than one cycle: still resets fully. No filtering is applied.
// CONFIGURATION
// - Macro RSTSEQ_SWRST_EN defined:
//   - Sw_rst port exists.
//   - Sw_rst sampled high in HOLD, RELEASE or DONE: on that edge, Rst_n = 0, Rst_done = 0,
//     state = HOLD, counter = 0.
//   - Sw_rst sampled high in SYNC: ignored.
//   - Synchroniser chain is never affected by Sw_rst.
//   - Sw_rst held high: stays in HOLD with counter = 0. Release restarts after Sw_rst falls:
//     Rst_n[0] rises STRETCH_CYCLES edges after the first edge with Sw_rst low.
//   - Asyncrst_n low has priority over Sw_rst.
// - Macro RSTSEQ_SWRST_EN undefined:
//   - Sw_rst port is absent. Internal request is tied to 0.
//   - Only Asyncrst_n can restart the sequence.
// TESTING
// - Power-up, defaults: Asyncrst_n low for 3 cycles, then high.
//   -> Rst_n = 4'b0000 through edge 17; 4'b0001 after edge 18; 4'b0011 after 26;
//      4'b0111 after 34; 4'b1111 and Rst_done = 1 after 42.
// - Async assert mid-RELEASE: Asyncrst_n low between edges 30 and 31.
//   -> Rst_n = 0 and Rst_done = 0 before edge 31, with no clock edge.
//   -> After release, the full sequence repeats: Rst_n[0] again 18 edges later.
// - Parameters N_OUT=1, SYNC_STAGES=3, STRETCH_CYCLES=1.
//   -> Rst_n[0] and Rst_done rise together on edge 4 after Asyncrst_n rises.
// - RSTSEQ_SWRST_EN, Sw_rst one-cycle pulse in DONE at edge e.
//   -> All Rst_n = 0 after edge e.
//   -> Rst_n[0] = 1 after e+16; Rst_n[3] and Rst_done = 1 after e+40.
// - RSTSEQ_SWRST_EN, Sw_rst held high 10 cycles during RELEASE.
//   -> Outputs stay 0 throughout.
//   -> Rst_n[0] rises 16 edges after the first edge sampling Sw_rst = 0.
// - Glitch: Asyncrst_n low for 2 ns between edges.
//   -> Outputs clear immediately; sequence restarts; ordering and monotonicity assertions hold.

Source files
------------

// File: rtl/reset_sequencer.sv
// Sequenced active-low reset generator: asynchronous assertion, synchronous ordered release.
// Optional software restart input Sw_rst is compiled in with `define RSTSEQ_SWRST_EN.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned N_OUT          = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STEP_CYCLES    = 8
) (
    input  logic             Clk,
    input  logic             Asyncrst_n,
`ifdef RSTSEQ_SWRST_EN
    input  logic             Sw_rst,
`endif
    output logic [N_OUT-1:0] Rst_n,
    output logic             Rst_done
);

    localparam int unsigned MAX_CYC = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (N_OUT < 1) begin : g_bad_nout
        $error("reset_sequencer: N_OUT must be >= 1");
    end
    if (STRETCH_CYCLES < 1 || STEP_CYCLES < 1) begin : g_bad_cyc
        $error("reset_sequencer: STRETCH_CYCLES and STEP_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [SYNC_STAGES-2:0]   r_sync;
    logic [N_OUT-1:0]         r_rst_n, w_rst_n_nxt, w_rst_n_ext;
    logic                     r_done, w_done_nxt;
    logic                     w_sw_rst;
    logic                     w_cnt_last;
    logic                     w_restart;

`ifdef RSTSEQ_SWRST_EN
    assign w_sw_rst = Sw_rst;
`else
    assign w_sw_rst = 1'b0;
`endif

    // The state flop is the final synchroniser stage: leaving SYNC is the sync_ok rising edge.
    always_ff @(posedge Clk or negedge Asyncrst_n) begin
        if (!Asyncrst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= 1'b1;
            for (int unsigned i = 1; i < SYNC_STAGES - 1; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Asyncrst_n) begin
        if (!Asyncrst_n) begin
            r_state <= SYNC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_last  = (r_state == HOLD) ? (r_cnt == CNT_W'(STRETCH_CYCLES - 1))
                                           : (r_cnt == CNT_W'(STEP_CYCLES - 1));
    assign w_rst_n_ext = N_OUT'({r_rst_n, 1'b1});
    assign w_restart   = w_sw_rst && (r_state != SYNC);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            SYNC: begin
                if (r_sync[SYNC_STAGES-2]) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD, RELEASE: begin
                if (w_cnt_last) begin
                    w_state_nxt = (&w_rst_n_ext) ? DONE : RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = DONE;
        endcase
        if (w_restart) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
        end
    end

    // Bits release as a thermometer, so ordering and monotonicity hold by construction.
    always_comb begin
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = r_done;
        if (w_restart) begin
            w_rst_n_nxt = '0;
            w_done_nxt  = 1'b0;
        end else if ((r_state == HOLD || r_state == RELEASE) && w_cnt_last) begin
            w_rst_n_nxt = w_rst_n_ext;
            w_done_nxt  = &w_rst_n_ext;
        end
    end

    always_ff @(posedge Clk or negedge Asyncrst_n) begin
        if (!Asyncrst_n) begin
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else begin
            r_rst_n <= w_rst_n_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Rst_n    = r_rst_n;
    assign Rst_done = r_done;

endmodule
